// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I fetch slice.
// Holds the decoder field widths, the canonical NOP encoding, the bit
// positions of the instruction fields and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned OPCODE_LENGTH  = 7;
  localparam int unsigned FUNCT3_LENGTH  = 3;
  localparam int unsigned FUNCT7_LENGTH  = 7;
  localparam int unsigned REG_IDX_LENGTH = 5;

  // addi x0,x0,0: presented to the decoder whenever no real instruction is held
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Least-significant bit of each field inside the instruction word
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter for the fetch stage.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   incr           advance pc by one word (instruction captured)
//   redirectValid  taken branch/jalr; wins over incr
//   redirectPc     redirect target; low two bits are dropped
//   pc             current fetch address (always word aligned)
//   misalign       one-cycle pulse after a redirect to a non-word-aligned target
module fetch_pc_gen #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  incr,
  input  logic                  redirectValid,
  input  logic [ADDR_WIDTH-1:0] redirectPc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  misalign
);

  logic [ADDR_WIDTH-1:0] pcQ;
  logic [ADDR_WIDTH-1:0] pcNext;
  logic                  misalignQ;

  // +4 wraps naturally modulo 2^ADDR_WIDTH
  always_comb begin
    pcNext = pcQ;
    if (redirectValid) begin
      pcNext = {redirectPc[ADDR_WIDTH-1:2], 2'b00};
    end else if (incr) begin
      pcNext = pcQ + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ       <= RESET_PC;
      misalignQ <= 1'b0;
    end else begin
      pcQ       <= pcNext;
      misalignQ <= redirectValid && (redirectPc[1:0] != 2'b00);
    end
  end

  assign pc       = pcQ;
  assign misalign = misalignQ;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the RV32I core.
// Issues one instruction-memory request at a time, captures the returned word
// into the instruction register and presents it (plus decoded fields) to the
// control decoder until downstream consumes it.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_ready   request handshake to instruction memory
//   imem_rvalid/imem_rdata          read data return
//   instr_ready                     downstream consumes the held instruction
//   redirect_valid/redirect_pc      taken branch/jalr from execute
//   instr_valid/instr/instr_pc      held instruction and its address
//   pc_plus4                        instr_pc + 4 (link value)
//   Opcode/Funct3/Funct7/rd/rs1/rs2 field slices of the held instruction
//   misalign                        pulse after a redirect to an unaligned target
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter int unsigned           INSTR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned           OPCODE_LENGTH = riscv_pkg::OPCODE_LENGTH,
  parameter int unsigned           FUNCT3_LENGTH = riscv_pkg::FUNCT3_LENGTH,
  parameter int unsigned           FUNCT7_LENGTH = riscv_pkg::FUNCT7_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  input  logic                     instr_ready,
  input  logic                     redirect_valid,
  input  logic [ADDR_WIDTH-1:0]    redirect_pc,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  output logic [ADDR_WIDTH-1:0]    pc_plus4,
  output logic [OPCODE_LENGTH-1:0] Opcode,
  output logic [FUNCT3_LENGTH-1:0] Funct3,
  output logic [FUNCT7_LENGTH-1:0] Funct7,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic                     misalign
);

  import riscv_pkg::*;

  fetch_state_t          state;
  fetch_state_t          stateNext;
  logic                  kill;
  logic                  killNext;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] instrPcQ;

  // A returning word is kept only if its request was not overtaken by a redirect
  assign capture = (state == S_WAIT) && imem_rvalid && !kill && !redirect_valid;

  fetch_pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) uPcGen (
    .clk           (clk),
    .rst_n         (rst_n),
    .incr          (capture),
    .redirectValid (redirect_valid),
    .redirectPc    (redirect_pc),
    .pc            (pc),
    .misalign      (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_REQ;
      kill  <= 1'b0;
    end else begin
      state <= stateNext;
      kill  <= killNext;
    end
  end

  // kill marks the single outstanding request as stale; it clears when that
  // request's data returns, so it never outlives one transaction.
  always_comb begin
    stateNext = state;
    killNext  = kill;
    unique case (state)
      S_REQ: begin
        killNext = 1'b0;
        if (imem_ready) begin
          stateNext = S_WAIT;
          killNext  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          killNext  = 1'b0;
          stateNext = capture ? S_HOLD : S_REQ;
        end else if (redirect_valid) begin
          killNext = 1'b1;
        end
      end
      S_HOLD: begin
        killNext = 1'b0;
        if (redirect_valid || instr_ready) begin
          stateNext = S_REQ;
        end
      end
      default: begin
        stateNext = S_REQ;
        killNext  = 1'b0;
      end
    endcase
  end

  // Request is masked while reset is asserted even though the state is S_REQ
  always_comb begin
    imem_req    = rst_n && (state == S_REQ);
    instr_valid = (state == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= INSTR_WIDTH'(NOP_INSTR);
      instrPcQ <= RESET_PC;
    end else if (capture) begin
      ir       <= imem_rdata;
      instrPcQ <= pc;
    end
  end

  assign imem_addr = pc;
  assign instr     = ir;
  assign instr_pc  = instrPcQ;
  assign pc_plus4  = instrPcQ + ADDR_WIDTH'(4);

  assign Opcode = ir[OPCODE_LSB +: OPCODE_LENGTH];
  assign Funct3 = ir[FUNCT3_LSB +: FUNCT3_LENGTH];
  assign Funct7 = ir[FUNCT7_LSB +: FUNCT7_LENGTH];
  assign rd     = ir[RD_LSB     +: REG_IDX_LENGTH];
  assign rs1    = ir[RS1_LSB    +: REG_IDX_LENGTH];
  assign rs2    = ir[RS2_LSB    +: REG_IDX_LENGTH];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit.
// A second instance with RESET_PC at the top of the address space shares all
// inputs and is used to observe the pc wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready, imem_rvalid, instr_ready, redirect_valid;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, instr, instr_pc, pc_plus4;
  logic [6:0]  Opcode, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  rd, rs1, rs2;

  logic        wImemReq, wInstrValid, wMisalign;
  logic [31:0] wImemAddr, wInstr, wInstrPc, wPcPlus4;
  logic [6:0]  wOpcode, wFunct7;
  logic [2:0]  wFunct3;
  logic [4:0]  wRd, wRs1, wRs2;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [63:0] expQ[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .misalign(misalign)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wImemReq), .imem_addr(wImemAddr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(wInstrValid), .instr(wInstr), .instr_pc(wInstrPc), .pc_plus4(wPcPlus4),
    .Opcode(wOpcode), .Funct3(wFunct3), .Funct7(wFunct7),
    .rd(wRd), .rs1(wRs1), .rs2(wRs2), .misalign(wMisalign)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clean fetch: wait (bounded) for the request, accept it, return data one
  // cycle later and check the captured instruction. Leaves it held.
  task automatic doFetch(input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] exp;
    int unsigned n = 0;
    while (!imem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkVal("reqSeen", imem_req, 1);
    checkVal("reqAddr", imem_addr, addr);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    expQ.push_back({addr, data});
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkVal("instrValid", instr_valid, 1);
    if (expQ.size() != 0) begin
      exp = expQ.pop_front();
      checkVal("instr", instr, exp[31:0]);
      checkVal("instrPc", instr_pc, exp[63:32]);
      checkVal("pcPlus4", pc_plus4, exp[63:32] + 32'd4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);

    // reset state
    checkVal("rstReq", imem_req, 0);
    checkVal("rstValid", instr_valid, 0);
    checkVal("rstInstr", instr, NOP);
    checkVal("rstInstrPc", instr_pc, 0);
    checkVal("rstMisalign", misalign, 0);
    checkVal("rstOpcode", Opcode, 7'b0010011);
    checkVal("rstWrapInstrPc", wInstrPc, 32'hFFFF_FFFC);

    // 1: first fetch, exact latency
    rst_n = 1'b1;
    #1;
    checkVal("t1Req", imem_req, 1);
    checkVal("t1Addr", imem_addr, 0);
    checkVal("t1WrapAddr", wImemAddr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    checkVal("t1WaitReq", imem_req, 0);
    checkVal("t1WaitValid", instr_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = NOP;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkVal("t1Valid", instr_valid, 1);
    checkVal("t1Instr", instr, NOP);
    checkVal("t1Opcode", Opcode, 7'b0010011);
    checkVal("t1Funct3", Funct3, 0);
    checkVal("t1Funct7", Funct7, 0);
    checkVal("t1PcPlus4", pc_plus4, 4);
    // 5: wrap instance
    checkVal("t5InstrPc", wInstrPc, 32'hFFFF_FFFC);
    checkVal("t5PcPlus4", wPcPlus4, 0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkVal("t1NextAddr", imem_addr, 4);
    checkVal("t1ValidDrop", instr_valid, 0);
    checkVal("t5NextAddr", wImemAddr, 0);

    // 2: sub x10,x10,x11 held under stall
    doFetch(32'h4, 32'h40B5_0533);
    for (int i = 0; i < 4; i++) begin
      checkVal("t2Opcode", Opcode, 7'b0110011);
      checkVal("t2Funct7", Funct7, 7'b0100000);
      checkVal("t2Rd", rd, 10);
      checkVal("t2Rs1", rs1, 10);
      checkVal("t2Rs2", rs2, 11);
      checkVal("t2NoReq", imem_req, 0);
      checkVal("t2Held", instr_valid, 1);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkVal("t2Req", imem_req, 1);
    checkVal("t2Addr", imem_addr, 8);

    // 3: redirect with simultaneous rvalid in S_WAIT
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    checkVal("t3Valid", instr_valid, 0);
    checkVal("t3Req", imem_req, 1);
    checkVal("t3Addr", imem_addr, 32'h100);
    checkVal("t3Misalign", misalign, 0);

    // 4: unaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    checkVal("t4Misalign", misalign, 1);
    checkVal("t4Addr", imem_addr, 32'h100);
    @(negedge clk);
    checkVal("t4MisalignEnd", misalign, 0);

    // redirect in S_WAIT, late data discarded
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    checkVal("killWaitReq", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkVal("killValid", instr_valid, 0);
    checkVal("killAddr", imem_addr, 32'h200);
    checkVal("killReq", imem_req, 1);

    // redirect in S_HOLD beats instr_ready
    doFetch(32'h200, 32'h00A0_0093);
    redirect_valid = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b0;
    checkVal("holdRedirValid", instr_valid, 0);
    checkVal("holdRedirAddr", imem_addr, 32'h300);

    // redirect while request accepted in S_REQ
    imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    imem_ready = 1'b0; redirect_valid = 1'b0;
    checkVal("reqKillReq", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkVal("reqKillValid", instr_valid, 0);
    checkVal("reqKillAddr", imem_addr, 32'h400);
    doFetch(32'h400, 32'h0020_8133);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkVal("postAddr", imem_addr, 32'h404);

    // 6: reset during S_WAIT, stale rvalid afterwards
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkVal("t6RstReq", imem_req, 0);
    checkVal("t6RstValid", instr_valid, 0);
    checkVal("t6RstInstr", instr, NOP);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checkVal("t6Valid", instr_valid, 0);
    checkVal("t6Instr", instr, NOP);
    checkVal("t6Req", imem_req, 1);
    checkVal("t6Addr", imem_addr, 0);
    doFetch(32'h0, 32'h0050_0113);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checkVal("t6NextAddr", imem_addr, 4);

    checkVal("queueEmpty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
